pet_stats_engine: RTL
=====================

PET_STATS_ENGINE -- requirements
Module: pet_stats_engine

Interface
REQ-001 SHALL have parameter NUM_NEEDS, default 4: number of need channels (food, sleep, fun, health order, channel 0 first).
REQ-002 SHALL have parameter VAL_W, default 3: width of each need value; maximum value MAXV = 2^VAL_W-1.
REQ-003 SHALL have parameter TICK_DIV, default 50000000: Clk cycles per game tick.
REQ-004 SHALL have parameters DECAY_TICKS (default 5), REFILL (default 2), LOW_THR (default 2) and CRIT_TICKS (default 10): ticks per decay step, refill amount, low threshold and ticks at zero before death.
REQ-005 SHALL have ports:
- Clk  input  1  clock.
- Rst  input  1  asynchronous, active-low reset.
- event_req  input  NUM_NEEDS  per-channel refill request; synchronous, debounced upstream.
- pause  input  1  freezes game time.
- need_val  output  NUM_NEEDS*VAL_W  need values; channel i at bits [i*VAL_W +: VAL_W].
- happy_val  output  VAL_W  minimum of all need values.
- mode  output  2  00 OK, 01 LOW, 10 CRIT, 11 DEAD.
- tick  output  1  one-cycle game-tick pulse.

Function
REQ-006 Tick counter SHALL count 0..TICK_DIV-1; tick SHALL be high for exactly the cycle the counter is at TICK_DIV-1, then wrap to 0.
REQ-007 While pause is high, tick counter, decay counters and CRIT counter SHALL hold; tick SHALL be 0.
REQ-008 Each channel SHALL have a decay counter incremented on tick; on the tick where it reaches DECAY_TICKS it SHALL clear and the need SHALL decrement by 1, saturating at 0.
REQ-009 Refill SHALL trigger on a rising edge of event_req[i] (high this edge, low previous edge); need SHALL increase by REFILL, saturating at MAXV, visible on need_val after that same edge.
REQ-010 Refill and decay in the same cycle on one channel SHALL both apply: result = sat(value - 1 + REFILL) in 0..MAXV.
REQ-011 Event level held high SHALL produce one refill only; channels SHALL be independent, simultaneous edges on several channels all apply.
REQ-012 happy_val and mode SHALL be registered, lagging need_val by one cycle.
REQ-013 Mode FSM, evaluated every cycle from need values:
- OK: all needs > LOW_THR.
- LOW: some need <= LOW_THR, none zero.
- CRIT: some need == 0; CRIT counter increments per tick while in CRIT.
- CRIT -> DEAD on the tick the CRIT counter reaches CRIT_TICKS.
- Leaving CRIT (no zero need) SHALL clear CRIT counter; go to OK or LOW per rules above.
- OK/LOW/CRIT transitions SHALL be direct in any direction.
REQ-014 DEAD SHALL be terminal until reset: needs frozen, events ignored, decay stopped; tick keeps running.

Reset
REQ-015 Rst low SHALL immediately force: all needs = MAXV, happy_val = MAXV, mode = OK, tick = 0, all counters = 0, event edge history = 0.
REQ-016 Reset mid-operation (including in DEAD) SHALL restore REQ-015 state; first tick SHALL occur TICK_DIV cycles after release.

Configuration
REQ-017 Macro PET_REVIVE_EN: defined -> extra input port revive (1 bit); rising edge of revive while mode = DEAD SHALL set all needs to REFILL, clear all counters and set mode per REQ-013 next cycle; revive ignored outside DEAD. Undefined -> no revive port; DEAD exits only via Rst.

Verification (NUM_NEEDS=4, VAL_W=3, TICK_DIV=4, DECAY_TICKS=2, REFILL=2, LOW_THR=2, CRIT_TICKS=3)
REQ-018 Reset release, no events -> tick every 4 cycles; all needs 7->6 after 8 cycles, mode LOW after 40 cycles (needs=2), CRIT after 56 cycles (needs=0), DEAD after 68 cycles.
REQ-019 Needs at 6, rising edge on event_req[1] held high 20 cycles -> need1 = 7 (saturated), exactly one refill, other channels unchanged.
REQ-020 Refill edge on channel 0 coinciding with its decay cycle, value 3 -> value 4.
REQ-021 In CRIT with counter at 2, refill channel at 0 -> mode leaves CRIT to LOW, counter cleared; return to CRIT requires 3 further ticks before DEAD.
REQ-022 pause high 40 cycles from reset -> needs remain 7, tick 0 throughout; in DEAD, event edges -> needs unchanged; Rst low -> needs 7, mode OK.
REQ-023 PET_REVIVE_EN defined, DEAD, revive edge -> all needs 2, mode LOW one cycle later; revive edge in OK -> no change.

Source files
------------

// File: rtl/pet_stats_engine.sv
// ---------------------------------------------------------------------------
// pet_stats_engine
//
// Virtual-pet need tracker. A free-running tick divider produces the game
// tick. Each need channel decays by one every DECAY_TICKS ticks and is
// refilled by REFILL on a rising edge of its event request. The mode FSM
// classifies the needs as OK / LOW / CRIT and moves to the terminal DEAD
// state after CRIT_TICKS ticks spent in CRIT.
//
// Ports
//   Clk        clock
//   Rst        asynchronous active-low reset
//   event_req  per-channel refill request (synchronous, debounced)
//   pause      freezes game time (tick, decay and CRIT counting)
//   revive     (PET_REVIVE_EN only) rising edge revives a DEAD pet
//   need_val   packed need values, channel i at [i*VAL_W +: VAL_W]
//   happy_val  registered minimum of all needs
//   mode       registered mode: 00 OK, 01 LOW, 10 CRIT, 11 DEAD
//   tick       one-cycle game-tick pulse
//
// Optional feature macro: PET_REVIVE_EN (adds the revive input).
// ---------------------------------------------------------------------------
module pet_stats_engine #(
    parameter int NUM_NEEDS   = 4,
    parameter int VAL_W       = 3,
    parameter int TICK_DIV    = 50000000,
    parameter int DECAY_TICKS = 5,
    parameter int REFILL      = 2,
    parameter int LOW_THR     = 2,
    parameter int CRIT_TICKS  = 10
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_NEEDS-1:0]         event_req,
    input  logic                         pause,
`ifdef PET_REVIVE_EN
    input  logic                         revive,
`endif
    output logic [NUM_NEEDS*VAL_W-1:0]   need_val,
    output logic [VAL_W-1:0]             happy_val,
    output logic [1:0]                   mode,
    output logic                         tick
);

    localparam int MAXV = (1 << VAL_W) - 1;
    localparam int TCW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DCW  = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    // The CRIT counter must be able to hold CRIT_TICKS itself once DEAD.
    localparam int CCW  = $clog2(CRIT_TICKS + 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OK   = 2'b00,
        MODE_LOW  = 2'b01,
        MODE_CRIT = 2'b10,
        MODE_DEAD = 2'b11
    } mode_e;

    mode_e                mode_q, mode_d;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [CCW-1:0]       crit_cnt_q, crit_cnt_d;
    logic [NUM_NEEDS-1:0] evt_prev_q;
    logic [VAL_W-1:0]     happy_q, happy_d;
    logic                 alive;
    logic                 any_zero, any_low;
    logic                 revive_fire;
    logic                 revive_pend;

    assign tick  = !pause && (tick_cnt_q == TICK_LAST);
    assign alive = (mode_q != MODE_DEAD);

`ifdef PET_REVIVE_EN
    logic revive_prev_q, revive_pend_q;

    assign revive_fire = revive && !revive_prev_q && (mode_q == MODE_DEAD);
    // Mode is re-evaluated from the revived needs one cycle after the revive
    // edge, keeping the usual one-cycle lag of mode behind need_val.
    assign revive_pend = revive_pend_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            revive_prev_q <= 1'b0;
            revive_pend_q <= 1'b0;
        end else begin
            revive_prev_q <= revive;
            revive_pend_q <= revive_fire;
        end
    end
`else
    assign revive_fire = 1'b0;
    assign revive_pend = 1'b0;
`endif

    // Game-tick divider.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (revive_fire) begin
            tick_cnt_d = '0;
        end else if (!pause) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Per-channel need value and decay counter.
    for (genvar gi = 0; gi < NUM_NEEDS; gi++) begin : g_need
        logic [VAL_W-1:0] need_q, need_d;
        logic [DCW-1:0]   dcnt_q, dcnt_d;
        logic             rise, dec;
        int               sum;

        assign rise = event_req[gi] && !evt_prev_q[gi];
        assign dec  = tick && (dcnt_q == DCW'(DECAY_TICKS - 1));

        always_comb begin
            need_d = need_q;
            dcnt_d = dcnt_q;
            sum    = 0;
            if (revive_fire) begin
                need_d = VAL_W'((REFILL > MAXV) ? MAXV : REFILL);
                dcnt_d = '0;
            end else if (alive) begin
                if (tick) begin
                    dcnt_d = dec ? '0 : dcnt_q + 1'b1;
                end
                // Refill and decay combine before saturation.
                sum = int'(need_q) + (rise ? REFILL : 0) - (dec ? 1 : 0);
                if (sum < 0) begin
                    need_d = '0;
                end else if (sum > MAXV) begin
                    need_d = VAL_W'(MAXV);
                end else begin
                    need_d = VAL_W'(sum);
                end
            end
        end

        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                need_q <= VAL_W'(MAXV);
                dcnt_q <= '0;
            end else begin
                need_q <= need_d;
                dcnt_q <= dcnt_d;
            end
        end

        assign need_val[gi*VAL_W +: VAL_W] = need_q;
    end

    // Need classification and minimum.
    always_comb begin
        happy_d  = VAL_W'(MAXV);
        any_zero = 1'b0;
        any_low  = 1'b0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            if (need_val[i*VAL_W +: VAL_W] < happy_d) begin
                happy_d = need_val[i*VAL_W +: VAL_W];
            end
            if (need_val[i*VAL_W +: VAL_W] == '0) begin
                any_zero = 1'b1;
            end
            if (int'(need_val[i*VAL_W +: VAL_W]) <= LOW_THR) begin
                any_low = 1'b1;
            end
        end
    end

    // Mode FSM next state.
    always_comb begin
        mode_d     = mode_q;
        crit_cnt_d = crit_cnt_q;
        if (revive_fire) begin
            crit_cnt_d = '0;
        end else if ((mode_q == MODE_DEAD) && !revive_pend) begin
            mode_d = MODE_DEAD;
        end else if (any_zero) begin
            mode_d = MODE_CRIT;
            // Only ticks spent already in CRIT count toward death.
            if ((mode_q == MODE_CRIT) && tick) begin
                crit_cnt_d = crit_cnt_q + 1'b1;
                if (crit_cnt_q == CCW'(CRIT_TICKS - 1)) begin
                    mode_d = MODE_DEAD;
                end
            end
        end else begin
            crit_cnt_d = '0;
            mode_d     = any_low ? MODE_LOW : MODE_OK;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mode_q     <= MODE_OK;
            tick_cnt_q <= '0;
            crit_cnt_q <= '0;
            evt_prev_q <= '0;
            happy_q    <= VAL_W'(MAXV);
        end else begin
            mode_q     <= mode_d;
            tick_cnt_q <= tick_cnt_d;
            crit_cnt_q <= crit_cnt_d;
            evt_prev_q <= event_req;
            happy_q    <= happy_d;
        end
    end

    assign mode      = mode_q;
    assign happy_val = happy_q;

endmodule
